// File: rtl/snax_simbacore_csr_ctrl.sv
// rtl/snax_simbacore_csr_ctrl.sv - CSR-side job controller for SimbaCore: config launch and output-beat tracking
//
// Purpose:
//   Accepts a job from the CSR manager and latches its config words. It then
//   presents them to SimbaCore through a valid/ready config handshake. After that
//   it counts output beats on the monitored acc2stream ports until the expected
//   total is reached. Busy/done status and a cycle counter are exported as
//   read-only CSR words.
//
// Ports:
//   clk_i                 rising-edge clock
//   rst_i                 synchronous active-high reset
//   csr_reg_set_i         RegRWCount config words; word [CfgCount] is the expected beat total
//   csr_reg_set_valid_i   CSR manager offers a new job
//   csr_reg_set_ready_o   controller can accept a job (IDLE only)
//   csr_reg_ro_set_o      status words: [0] = {done, busy}, [1] = cycle count
//   cfg_bits_o            latched config words to SimbaCore io_config_bits_*
//   cfg_valid_o           SimbaCore io_config_valid
//   cfg_ready_i           SimbaCore io_config_ready
//   out_valid_i           acc2stream valid taps
//   out_ready_i           acc2stream ready taps

module snax_simbacore_csr_ctrl #(
    parameter int RegDataWidth = 32,
    parameter int CfgCount     = 5,
    parameter int RegRWCount   = 6,
    parameter int RegROCount   = 2,
    parameter int NumOut       = 3
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic [RegRWCount-1:0][RegDataWidth-1:0]  csr_reg_set_i,
    input  logic                                     csr_reg_set_valid_i,
    output logic                                     csr_reg_set_ready_o,
    output logic [RegROCount-1:0][RegDataWidth-1:0]  csr_reg_ro_set_o,
    output logic [CfgCount-1:0][RegDataWidth-1:0]    cfg_bits_o,
    output logic                                     cfg_valid_o,
    input  logic                                     cfg_ready_i,
    input  logic [NumOut-1:0]                        out_valid_i,
    input  logic [NumOut-1:0]                        out_ready_i
);

    localparam int IncW = $clog2(NumOut + 1);
    localparam int SumW = RegDataWidth + 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t                  state;
    logic [RegDataWidth-1:0] exp_cnt;
    logic [RegDataWidth-1:0] beat_cnt;
    logic [RegDataWidth-1:0] cycle_cnt;
    logic                    done;

    logic [IncW-1:0]         inc;
    logic [SumW-1:0]         beat_sum;
    logic                    beat_reached;
    logic [RegDataWidth-1:0] beat_next;
    logic                    job_accept;
    logic                    cfg_fire;
    logic                    busy;

    // Number of beats that completed a handshake this cycle, across all ports.
    always_comb begin
        inc = '0;
        for (int i = 0; i < NumOut; i++) begin
            inc = inc + IncW'(out_valid_i[i] & out_ready_i[i]);
        end
    end

    // Widened sum so the end-of-job compare never suffers from wrap; the stored
    // count itself saturates instead of wrapping.
    always_comb begin
        beat_sum     = {2'b00, beat_cnt} + SumW'(inc);
        beat_reached = (beat_sum >= {2'b00, exp_cnt});
        if (beat_sum[SumW-1:RegDataWidth] != 2'b00) begin
            beat_next = '1;
        end else begin
            beat_next = beat_sum[RegDataWidth-1:0];
        end
    end

    assign csr_reg_set_ready_o = (state == IDLE);
    assign job_accept          = csr_reg_set_valid_i & csr_reg_set_ready_o;
    assign cfg_fire            = cfg_valid_o & cfg_ready_i;
    assign busy                = (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cfg_valid_o <= 1'b0;
            cfg_bits_o  <= '0;
            exp_cnt     <= '0;
            beat_cnt    <= '0;
            cycle_cnt   <= '0;
            done        <= 1'b0;
        end else begin
            // Cycle counter covers every cycle the job is in flight.
            if (state != IDLE && cycle_cnt != '1) begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (job_accept) begin
                        for (int i = 0; i < CfgCount; i++) begin
                            cfg_bits_o[i] <= csr_reg_set_i[i];
                        end
                        exp_cnt     <= csr_reg_set_i[CfgCount];
                        beat_cnt    <= '0;
                        cycle_cnt   <= '0;
                        done        <= 1'b0;
                        cfg_valid_o <= 1'b1;
                        state       <= LAUNCH;
                    end
                end

                LAUNCH: begin
                    // cfg_bits_o is not touched here, so it stays stable
                    // for as long as SimbaCore withholds ready.
                    if (cfg_fire) begin
                        cfg_valid_o <= 1'b0;
                        if (exp_cnt == '0) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            state <= RUN;
                        end
                    end
                end

                RUN: begin
                    beat_cnt <= beat_next;
                    if (beat_reached) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end

                default: begin
                    cfg_valid_o <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        csr_reg_ro_set_o    = '0;
        csr_reg_ro_set_o[0] = {{(RegDataWidth-2){1'b0}}, done, busy};
        csr_reg_ro_set_o[1] = cycle_cnt;
    end

endmodule

// File: tb/tb_snax_simbacore_csr_ctrl.sv
// tb/tb_snax_simbacore_csr_ctrl.sv - directed self-checking bench for snax_simbacore_csr_ctrl

module tb_snax_simbacore_csr_ctrl;

    logic              clk = 1'b0;
    logic              rst;
    logic [5:0][31:0]  set_words;
    logic              set_valid;
    logic              set_ready;
    logic [1:0][31:0]  ro_words;
    logic [4:0][31:0]  cfg_bits;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [2:0]        out_valid;
    logic [2:0]        out_ready;

    int n_checks = 0;
    int n_fails  = 0;

    logic [159:0] cfg_snap;

    always #5 clk = ~clk;

    snax_simbacore_csr_ctrl #(
        .RegDataWidth (32),
        .CfgCount     (5),
        .RegRWCount   (6),
        .RegROCount   (2),
        .NumOut       (3)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .csr_reg_set_i       (set_words),
        .csr_reg_set_valid_i (set_valid),
        .csr_reg_set_ready_o (set_ready),
        .csr_reg_ro_set_o    (ro_words),
        .cfg_bits_o          (cfg_bits),
        .cfg_valid_o         (cfg_valid),
        .cfg_ready_i         (cfg_ready),
        .out_valid_i         (out_valid),
        .out_ready_i         (out_ready)
    );

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] w0, w1, w2, w3, w4, w5);
        set_words[0] = w0;
        set_words[1] = w1;
        set_words[2] = w2;
        set_words[3] = w3;
        set_words[4] = w4;
        set_words[5] = w5;
    endtask

    task automatic fires(input logic [2:0] v, input logic [2:0] r);
        out_valid = v;
        out_ready = r;
    endtask

    initial begin
        rst       = 1'b1;
        set_words = '0;
        set_valid = 1'b0;
        cfg_ready = 1'b0;
        out_valid = '0;
        out_ready = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_ready", 160'(set_ready), 160'd1);
        chk("rst_cfg_valid", 160'(cfg_valid), 160'd0);
        chk("rst_cfg_bits", cfg_bits, 160'd0);
        chk("rst_ro0", 160'(ro_words[0]), 160'd0);
        chk("rst_ro1", 160'(ro_words[1]), 160'd0);

        // Basic job: exp=8, ready after 2 LAUNCH cycles, single-port fires
        load(32'd1, 32'd64, 32'd16, 32'd4, 32'd32, 32'd8);
        set_valid = 1'b1;
        tick();
        set_valid = 1'b0;
        chk("basic_cfg_valid", 160'(cfg_valid), 160'd1);
        chk("basic_cfg_bits", cfg_bits, {32'd32, 32'd4, 32'd16, 32'd64, 32'd1});
        chk("basic_ready_low", 160'(set_ready), 160'd0);
        chk("basic_ro0_busy", 160'(ro_words[0]), 160'd1);
        tick();
        tick();
        chk("basic_hold_valid", 160'(cfg_valid), 160'd1);
        cfg_ready = 1'b1;
        tick();
        cfg_ready = 1'b0;
        chk("basic_run_cfg_valid", 160'(cfg_valid), 160'd0);
        chk("basic_run_ro1", 160'(ro_words[1]), 160'd3);
        fires(3'b001, 3'b001);
        for (int i = 0; i < 7; i++) tick();
        chk("basic_busy_after7", 160'(ro_words[0]), 160'd1);
        chk("basic_beats7", 160'(dut.beat_cnt), 160'd7);
        tick();
        fires(3'b000, 3'b000);
        chk("basic_ro0_done", 160'(ro_words[0]), 160'd2);
        chk("basic_ro1", 160'(ro_words[1]), 160'd11);
        chk("basic_ready_back", 160'(set_ready), 160'd1);
        tick();
        chk("basic_ro1_hold", 160'(ro_words[1]), 160'd11);
        chk("basic_done_sticky", 160'(ro_words[0]), 160'd2);

        // Multi-port: exp=6, all three ports for 2 cycles
        load(32'd2, 32'd8, 32'd8, 32'd2, 32'd16, 32'd6);
        cfg_ready = 1'b1;
        set_valid = 1'b1;
        tick();
        set_valid = 1'b0;
        chk("multi_done_cleared", 160'(ro_words[0]), 160'd1);
        chk("multi_ro1_cleared", 160'(ro_words[1]), 160'd0);
        tick();
        fires(3'b111, 3'b111);
        tick();
        chk("multi_busy_mid", 160'(ro_words[0]), 160'd1);
        chk("multi_beats3", 160'(dut.beat_cnt), 160'd3);
        tick();
        fires(3'b000, 3'b000);
        chk("multi_done", 160'(ro_words[0]), 160'd2);
        chk("multi_ro1", 160'(ro_words[1]), 160'd3);
        chk("multi_beats", 160'(dut.beat_cnt), 160'd6);

        // Overshoot: exp=5, 3 beats then 3 beats
        load(32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd5);
        set_valid = 1'b1;
        tick();
        set_valid = 1'b0;
        tick();
        fires(3'b111, 3'b111);
        tick();
        chk("over_busy_mid", 160'(ro_words[0]), 160'd1);
        tick();
        fires(3'b000, 3'b000);
        chk("over_done", 160'(ro_words[0]), 160'd2);
        chk("over_beats", 160'(dut.beat_cnt), 160'd6);
        tick();
        chk("over_idle_ready", 160'(set_ready), 160'd1);

        // Zero job: exp=0, fires during LAUNCH are ignored
        load(32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd0);
        cfg_ready = 1'b0;
        set_valid = 1'b1;
        tick();
        set_valid = 1'b0;
        fires(3'b111, 3'b111);
        chk("zero_cfg_valid", 160'(cfg_valid), 160'd1);
        cfg_ready = 1'b1;
        tick();
        fires(3'b000, 3'b000);
        chk("zero_done", 160'(ro_words[0]), 160'd2);
        chk("zero_ro1", 160'(ro_words[1]), 160'd1);
        chk("zero_cfg_valid_low", 160'(cfg_valid), 160'd0);
        chk("zero_beats", 160'(dut.beat_cnt), 160'd0);
        chk("zero_cfg_bits", cfg_bits, {32'd9, 32'd8, 32'd7, 32'd6, 32'd5});

        // Backpressure: cfg_ready low for 10 cycles, new words offered meanwhile
        load(32'd3, 32'd30, 32'd300, 32'd3000, 32'd30000, 32'd4);
        cfg_ready = 1'b0;
        set_valid = 1'b1;
        tick();
        cfg_snap = cfg_bits;
        chk("bp_bits", cfg_snap, {32'd30000, 32'd3000, 32'd300, 32'd30, 32'd3});
        load(32'hdead, 32'hbeef, 32'hcafe, 32'hf00d, 32'h1234, 32'd1);
        fires(3'b111, 3'b111);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid_held", 160'(cfg_valid), 160'd1);
            chk("bp_bits_stable", cfg_bits, cfg_snap);
            chk("bp_ready_low", 160'(set_ready), 160'd0);
        end
        set_valid = 1'b0;
        chk("bp_beats_ignored", 160'(dut.beat_cnt), 160'd0);
        chk("bp_ro1", 160'(ro_words[1]), 160'd10);
        fires(3'b000, 3'b000);
        cfg_ready = 1'b1;
        tick();
        chk("bp_run_busy", 160'(ro_words[0]), 160'd1);
        fires(3'b011, 3'b110);
        tick();
        chk("bp_masked_beats", 160'(dut.beat_cnt), 160'd1);
        fires(3'b111, 3'b101);
        tick();
        chk("bp_busy_at3", 160'(ro_words[0]), 160'd1);
        fires(3'b010, 3'b010);
        tick();
        fires(3'b000, 3'b000);
        chk("bp_done", 160'(ro_words[0]), 160'd2);
        chk("bp_ro1_final", 160'(ro_words[1]), 160'd14);

        // Reset in RUN after 3 of 8 beats
        load(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd8);
        set_valid = 1'b1;
        tick();
        set_valid = 1'b0;
        tick();
        fires(3'b100, 3'b100);
        for (int i = 0; i < 3; i++) tick();
        chk("rr_beats3", 160'(dut.beat_cnt), 160'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fires(3'b000, 3'b000);
        chk("rr_cfg_valid", 160'(cfg_valid), 160'd0);
        chk("rr_cfg_bits", cfg_bits, 160'd0);
        chk("rr_ro0", 160'(ro_words[0]), 160'd0);
        chk("rr_ro1", 160'(ro_words[1]), 160'd0);
        chk("rr_ready", 160'(set_ready), 160'd1);
        chk("rr_beats", 160'(dut.beat_cnt), 160'd0);
        tick();
        tick();
        chk("rr_no_relaunch", 160'(cfg_valid), 160'd0);

        // Next job after reset: exp=2
        load(32'd7, 32'd7, 32'd7, 32'd7, 32'd7, 32'd2);
        set_valid = 1'b1;
        tick();
        set_valid = 1'b0;
        chk("post_cfg_valid", 160'(cfg_valid), 160'd1);
        tick();
        fires(3'b001, 3'b001);
        tick();
        chk("post_beats1", 160'(dut.beat_cnt), 160'd1);
        chk("post_busy", 160'(ro_words[0]), 160'd1);
        tick();
        fires(3'b000, 3'b000);
        chk("post_done", 160'(ro_words[0]), 160'd2);
        chk("post_ro1", 160'(ro_words[1]), 160'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
